// File: rtl/ssd_ctrl_if.sv
// Display-controller bus: base content, two message requesters, abort, display outputs.
// Latency: none, this is only the bundled set of signals.
// Backpressure: requesters hold req until they see their one-cycle ack.
interface ssd_ctrl_if;
   logic [31:0] base_disp;
   logic        req0;
   logic        req1;
   logic [31:0] msg0;
   logic [31:0] msg1;
   logic        clr;
   logic        ack0;
   logic        ack1;
   logic [7:0]  disp0;
   logic [7:0]  disp1;
   logic [7:0]  disp2;
   logic [7:0]  disp3;
   logic        busy;
   logic        src;

   modport master (
      output base_disp, req0, req1, msg0, msg1, clr,
      input  ack0, ack1, disp0, disp1, disp2, disp3, busy, src
   );

   modport slave (
      input  base_disp, req0, req1, msg0, msg1, clr,
      output ack0, ack1, disp0, disp1, disp2, disp3, busy, src
   );
endinterface

// File: rtl/ssd_ctrl.sv
// 4-digit display controller: shows base_disp, or a granted message for HOLD_CYCLES (SSD_BLINK_EN adds blinking).
// Latency: 1 cycle from base_disp/grant to disp; ack pulses in the first SHOW cycle.
// Backpressure: req0/req1 stay pending while held high; req0 preempts a req1 message, clr aborts.
module ssd_ctrl #(
   parameter int unsigned HOLD_CYCLES  = 50_000_000,
   parameter int unsigned BLINK_CYCLES = 12_500_000,
   parameter logic [7:0]  BLANK_PAT    = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   ssd_ctrl_if.slave  bus
);

   localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] BLANK_WORD = {4{BLANK_PAT}};

   // Reject illegal zero-length timing at elaboration.
   if (HOLD_CYCLES == 0) begin : g_hold_chk
      $error("HOLD_CYCLES must be at least 1");
   end
   if (BLINK_CYCLES == 0) begin : g_blink_chk
      $error("BLINK_CYCLES must be at least 1");
   end

   typedef enum logic {IDLE, SHOW} state_t;

   state_t      state, state_n;
   logic [31:0] hcnt, hcnt_n;
   logic [31:0] disp_q, disp_n;
   logic        src_q, src_n;
   logic        ack0_q, ack0_n;
   logic        ack1_q, ack1_n;
   logic        grant0, grant1;

`ifdef SSD_BLINK_EN
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
   logic [31:0] bcnt, bcnt_n;
   logic        phase, phase_n;
   logic [31:0] msg_q, msg_n;
`endif

   // Next-state, grant arbitration and display selection.
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      disp_n  = disp_q;
      src_n   = src_q;
      ack0_n  = 1'b0;
      ack1_n  = 1'b0;
      grant0  = 1'b0;
      grant1  = 1'b0;
`ifdef SSD_BLINK_EN
      bcnt_n  = bcnt;
      phase_n = phase;
      msg_n   = msg_q;
`endif
      case (state)
         IDLE: begin
            hcnt_n = '0;
            disp_n = bus.base_disp;
`ifdef SSD_BLINK_EN
            bcnt_n  = '0;
            phase_n = 1'b0;
`endif
            if (bus.req0) begin
               grant0 = 1'b1;
            end else if (bus.req1) begin
               grant1 = 1'b1;
            end
         end
         SHOW: begin
            // clr outranks preemption, which outranks hold expiry.
            if (bus.clr) begin
               state_n = IDLE;
               hcnt_n  = '0;
               disp_n  = bus.base_disp;
            end else if (bus.req0 && src_q) begin
               grant0 = 1'b1;
            end else if (hcnt == HOLD_LAST) begin
               state_n = IDLE;
               hcnt_n  = '0;
               disp_n  = bus.base_disp;
            end else begin
               hcnt_n = hcnt + 32'd1;
`ifdef SSD_BLINK_EN
               if (bcnt == BLINK_LAST) begin
                  bcnt_n  = '0;
                  phase_n = ~phase;
               end else begin
                  bcnt_n = bcnt + 32'd1;
               end
               disp_n = phase_n ? BLANK_WORD : msg_q;
`endif
            end
         end
         default: state_n = IDLE;
      endcase

      if (grant0 || grant1) begin
         state_n = SHOW;
         hcnt_n  = '0;
         src_n   = grant1;
         ack0_n  = grant0;
         ack1_n  = grant1;
         disp_n  = grant0 ? bus.msg0 : bus.msg1;
`ifdef SSD_BLINK_EN
         bcnt_n  = '0;
         phase_n = 1'b0;
         msg_n   = grant0 ? bus.msg0 : bus.msg1;
`endif
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         hcnt   <= '0;
         disp_q <= BLANK_WORD;
         src_q  <= 1'b0;
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
`ifdef SSD_BLINK_EN
         bcnt   <= '0;
         phase  <= 1'b0;
         msg_q  <= BLANK_WORD;
`endif
      end else begin
         state  <= state_n;
         hcnt   <= hcnt_n;
         disp_q <= disp_n;
         src_q  <= src_n;
         ack0_q <= ack0_n;
         ack1_q <= ack1_n;
`ifdef SSD_BLINK_EN
         bcnt   <= bcnt_n;
         phase  <= phase_n;
         msg_q  <= msg_n;
`endif
      end
   end

   assign bus.disp0 = disp_q[7:0];
   assign bus.disp1 = disp_q[15:8];
   assign bus.disp2 = disp_q[23:16];
   assign bus.disp3 = disp_q[31:24];
   assign bus.busy  = (state == SHOW);
   assign bus.src   = src_q;
   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;

endmodule

// File: tb/tb_ssd_ctrl.sv
// Bench for ssd_ctrl with HOLD_CYCLES=4, BLINK_CYCLES=2, BLANK_PAT=FF.
// Each scenario pushes the expected next-cycle outputs while driving, then pops and compares.
// src is only compared while the expected state is busy.
module tb_ssd_ctrl;

   localparam logic [31:0] B  = 32'h11223344;
   localparam logic [31:0] F  = 32'hFFFFFFFF;
   localparam logic [31:0] M0 = 32'hB1B2B3B4;
   localparam logic [31:0] M1 = 32'hA1A2A3A4;
   localparam logic [31:0] P  = 32'h01020304;
`ifdef SSD_BLINK_EN
   localparam logic [31:0] PB = F;
`else
   localparam logic [31:0] PB = P;
`endif

   // {rst, req0, req1, clr}
   typedef logic [3:0] stim_t;

   typedef struct packed {
      logic        ack0;
      logic        ack1;
      logic        busy;
      logic        src;
      logic [31:0] disp;
   } obs_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   obs_t exp_q[$];

   ssd_ctrl_if bus ();

   ssd_ctrl #(
      .HOLD_CYCLES (4),
      .BLINK_CYCLES(2),
      .BLANK_PAT   (8'hFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(input logic a0, input logic a1, input logic b,
                               input logic s, input logic [31:0] d);
      obs_t o;
      o.ack0 = a0;
      o.ack1 = a1;
      o.busy = b;
      o.src  = s;
      o.disp = d;
      return o;
   endfunction

   function automatic obs_t sample();
      return mk(bus.ack0, bus.ack1, bus.busy, bus.src,
                {bus.disp3, bus.disp2, bus.disp1, bus.disp0});
   endfunction

   // Drive one cycle of inputs, record what must appear after the edge.
   task automatic apply(input stim_t s, input obs_t e);
      rst      = s[3];
      bus.req0 = s[2];
      bus.req1 = s[1];
      bus.clr  = s[0];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t st[4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
      obs_t  ex[4];
      obs_t  e, o;
      ex[0] = mk(0, 0, 0, 0, F);
      ex[1] = mk(0, 0, 0, 0, F);
      ex[2] = mk(0, 0, 0, 0, B);
      ex[3] = mk(0, 0, 0, 0, B);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         e = exp_q.pop_front();
         o = sample();
         n_tests++;
         if (o.ack0 !== e.ack0 || o.ack1 !== e.ack1 || o.busy !== e.busy ||
             o.disp !== e.disp || (e.busy && o.src !== e.src)) begin
            n_fail++;
            $display("FAIL reset[%0d]: got ack0=%b ack1=%b busy=%b src=%b disp=%h, want ack0=%b ack1=%b busy=%b src=%b disp=%h",
                     i, o.ack0, o.ack1, o.busy, o.src, o.disp, e.ack0, e.ack1, e.busy, e.src, e.disp);
         end
      end
   endtask

   task automatic test_single();
      stim_t st[6] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      obs_t  ex[6];
      obs_t  e, o;
      ex[0] = mk(0, 1, 1, 1, M1);
      ex[1] = mk(0, 0, 1, 1, M1);
      ex[2] = mk(0, 0, 1, 1, M1);
      ex[3] = mk(0, 0, 1, 1, M1);
      ex[4] = mk(0, 0, 0, 0, B);
      ex[5] = mk(0, 0, 0, 0, B);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         e = exp_q.pop_front();
         o = sample();
         n_tests++;
         if (o.ack0 !== e.ack0 || o.ack1 !== e.ack1 || o.busy !== e.busy ||
             o.disp !== e.disp || (e.busy && o.src !== e.src)) begin
            n_fail++;
            $display("FAIL single[%0d]: got ack0=%b ack1=%b busy=%b src=%b disp=%h, want ack0=%b ack1=%b busy=%b src=%b disp=%h",
                     i, o.ack0, o.ack1, o.busy, o.src, o.disp, e.ack0, e.ack1, e.busy, e.src, e.disp);
         end
      end
   endtask

   task automatic test_simultaneous();
      stim_t st[10] = '{4'b0110, 4'b0110, 4'b0010, 4'b0010, 4'b0010,
                        4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      obs_t  ex[10];
      obs_t  e, o;
      ex[0] = mk(1, 0, 1, 0, M0);
      ex[1] = mk(0, 0, 1, 0, M0);
      ex[2] = mk(0, 0, 1, 0, M0);
      ex[3] = mk(0, 0, 1, 0, M0);
      ex[4] = mk(0, 0, 0, 0, B);
      ex[5] = mk(0, 1, 1, 1, M1);
      ex[6] = mk(0, 0, 1, 1, M1);
      ex[7] = mk(0, 0, 1, 1, M1);
      ex[8] = mk(0, 0, 1, 1, M1);
      ex[9] = mk(0, 0, 0, 0, B);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         e = exp_q.pop_front();
         o = sample();
         n_tests++;
         if (o.ack0 !== e.ack0 || o.ack1 !== e.ack1 || o.busy !== e.busy ||
             o.disp !== e.disp || (e.busy && o.src !== e.src)) begin
            n_fail++;
            $display("FAIL simultaneous[%0d]: got ack0=%b ack1=%b busy=%b src=%b disp=%h, want ack0=%b ack1=%b busy=%b src=%b disp=%h",
                     i, o.ack0, o.ack1, o.busy, o.src, o.disp, e.ack0, e.ack1, e.busy, e.src, e.disp);
         end
      end
   endtask

   task automatic test_preempt_abort();
      stim_t st[20] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0000,
                        4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100,
                        4'b0101, 4'b0000, 4'b0001, 4'b0010, 4'b0111,
                        4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
      obs_t  ex[20];
      obs_t  e, o;
      ex[0]  = mk(0, 1, 1, 1, M1);
      ex[1]  = mk(0, 0, 1, 1, M1);
      ex[2]  = mk(1, 0, 1, 0, M0);   // preempted two cycles in
      ex[3]  = mk(0, 0, 1, 0, M0);
      ex[4]  = mk(0, 0, 1, 0, M0);
      ex[5]  = mk(0, 0, 1, 0, M0);
      ex[6]  = mk(0, 0, 0, 0, B);
      ex[7]  = mk(0, 1, 1, 1, M1);
      ex[8]  = mk(0, 0, 1, 1, M1);
      ex[9]  = mk(1, 0, 1, 0, M0);
      ex[10] = mk(0, 0, 0, 0, B);    // clr one cycle into msg0
      ex[11] = mk(0, 0, 0, 0, B);
      ex[12] = mk(0, 0, 0, 0, B);    // clr while idle does nothing
      ex[13] = mk(0, 1, 1, 1, M1);
      ex[14] = mk(0, 0, 0, 0, B);    // clr beats preemption
      ex[15] = mk(1, 0, 1, 0, M0);   // pending req0 granted in first idle cycle
      ex[16] = mk(0, 0, 1, 0, M0);
      ex[17] = mk(0, 0, 1, 0, M0);
      ex[18] = mk(0, 0, 1, 0, M0);
      ex[19] = mk(0, 0, 0, 0, B);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         e = exp_q.pop_front();
         o = sample();
         n_tests++;
         if (o.ack0 !== e.ack0 || o.ack1 !== e.ack1 || o.busy !== e.busy ||
             o.disp !== e.disp || (e.busy && o.src !== e.src)) begin
            n_fail++;
            $display("FAIL preempt_abort[%0d]: got ack0=%b ack1=%b busy=%b src=%b disp=%h, want ack0=%b ack1=%b busy=%b src=%b disp=%h",
                     i, o.ack0, o.ack1, o.busy, o.src, o.disp, e.ack0, e.ack1, e.busy, e.src, e.disp);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t st[8] = '{4'b0010, 4'b0010, 4'b1010, 4'b0010,
                       4'b0010, 4'b0000, 4'b0000, 4'b0000};
      obs_t  ex[8];
      obs_t  e, o;
      ex[0] = mk(0, 1, 1, 1, M1);
      ex[1] = mk(0, 0, 1, 1, M1);
      ex[2] = mk(0, 0, 0, 0, F);
      ex[3] = mk(0, 1, 1, 1, M1);
      ex[4] = mk(0, 0, 1, 1, M1);
      ex[5] = mk(0, 0, 1, 1, M1);
      ex[6] = mk(0, 0, 1, 1, M1);
      ex[7] = mk(0, 0, 0, 0, B);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         e = exp_q.pop_front();
         o = sample();
         n_tests++;
         if (o.ack0 !== e.ack0 || o.ack1 !== e.ack1 || o.busy !== e.busy ||
             o.disp !== e.disp || (e.busy && o.src !== e.src)) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: got ack0=%b ack1=%b busy=%b src=%b disp=%h, want ack0=%b ack1=%b busy=%b src=%b disp=%h",
                     i, o.ack0, o.ack1, o.busy, o.src, o.disp, e.ack0, e.ack1, e.busy, e.src, e.disp);
         end
      end
   endtask

   task automatic test_blink();
      stim_t st[5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
      obs_t  ex[5];
      obs_t  e, o;
      bus.msg0 = P;
      ex[0] = mk(1, 0, 1, 0, P);
      ex[1] = mk(0, 0, 1, 0, P);
      ex[2] = mk(0, 0, 1, 0, PB);
      ex[3] = mk(0, 0, 1, 0, PB);
      ex[4] = mk(0, 0, 0, 0, B);
      foreach (st[i]) begin
         apply(st[i], ex[i]);
         e = exp_q.pop_front();
         o = sample();
         n_tests++;
         if (o.ack0 !== e.ack0 || o.ack1 !== e.ack1 || o.busy !== e.busy ||
             o.disp !== e.disp || (e.busy && o.src !== e.src)) begin
            n_fail++;
            $display("FAIL blink[%0d]: got ack0=%b ack1=%b busy=%b src=%b disp=%h, want ack0=%b ack1=%b busy=%b src=%b disp=%h",
                     i, o.ack0, o.ack1, o.busy, o.src, o.disp, e.ack0, e.ack1, e.busy, e.src, e.disp);
         end
      end
      bus.msg0 = M0;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.base_disp = B;
      bus.req0      = 1'b0;
      bus.req1      = 1'b0;
      bus.clr       = 1'b0;
      bus.msg0      = M0;
      bus.msg1      = M1;
      test_reset();
      test_single();
      test_simultaneous();
      test_preempt_abort();
      test_reset_mid();
      test_blink();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
